// File: rtl/cdc_hs_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hs_pkg
// Shared definitions for the four-phase req/ack clock-domain-crossing pair
// (cdc_hs_tx on the sending side, cdc_hs_rx on the receiving side).
//   hs_state_t              2-bit handshake state type
//   ST_IDLE/ST_REQ/ST_RELEASE  state encodings
//   DEFAULT_SYNC_STAGES     default depth of the resync flop chains
//   DEFAULT_TIMEOUT_CYCLES  default watchdog limit
// -----------------------------------------------------------------------------
package cdc_hs_pkg;

    typedef logic [1:0] hs_state_t;

    localparam hs_state_t ST_IDLE    = 2'd0;  // ready for a new word
    localparam hs_state_t ST_REQ     = 2'd1;  // req high, waiting for ack high
    localparam hs_state_t ST_RELEASE = 2'd2;  // req low, waiting for ack low

    localparam int DEFAULT_SYNC_STAGES    = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage : cdc_hs_pkg

// File: rtl/cdc_hs_sync.sv
// -----------------------------------------------------------------------------
// cdc_hs_sync
// Single-bit resynchroniser: a STAGES-deep flop chain that brings an
// asynchronous level into the clk domain. Legal STAGES range is 2..4.
// The chain flops carry keep/preserve/ASYNC_REG attributes so synthesis
// neither merges nor retimes them and the flops end up placed together.
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears every stage
//   d      asynchronous input level
//   q      synchronised level (last stage)
// -----------------------------------------------------------------------------
module cdc_hs_sync
    import cdc_hs_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE", keep = "true", preserve = "true" *)
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every stage
            // samples the previous stage's old value; blocking would collapse
            // the chain into a single flop.
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : cdc_hs_sync

// File: rtl/cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// cdc_hs_tx
// Source-domain initiator of a four-phase req/ack handshake carrying a
// DATA_WIDTH-bit word into an unrelated clock domain. A word accepted on the
// valid/ready port is held on xfer_data while xfer_req is raised; the cycle
// completes once the resynchronised ack has gone high and then low again.
//
// Optional feature: define CDC_HS_TX_TIMEOUT_EN to build a watchdog that sets
// the sticky timeout_err flag when a handshake stalls for TIMEOUT_CYCLES in
// REQ or RELEASE. Without it timeout_err is tied low and err_clr is unused.
//
// Ports
//   source_clk   sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_data      word to send
//   in_valid     in_data valid
//   in_ready     block can accept (IDLE and synced ack low), registers only
//   xfer_data    registered word towards the destination domain
//   xfer_req     registered request towards the destination domain
//   xfer_ack     asynchronous acknowledge from the destination domain
//   xfer_done    one-cycle pulse when a handshake fully completes
//   err_clr      clears timeout_err
//   timeout_err  sticky watchdog flag
// -----------------------------------------------------------------------------
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
    parameter int                    SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int                    TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  source_clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  xfer_req,
    input  logic                  xfer_ack,
    output logic                  xfer_done,
    input  logic                  err_clr,
    output logic                  timeout_err
);

    hs_state_t state;
    hs_state_t state_next;
    logic      ack_s;
    logic      accept;

    cdc_hs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (source_clk),
        .rst_n (reset_n),
        .d     (xfer_ack),
        .q     (ack_s)
    );

    // A stale ack seen in IDLE holds off new words until it drops, so the
    // destination never sees a fresh req while its previous ack is still up.
    assign in_ready = (state == ST_IDLE) && !ack_s;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: default assignment first so every path drives state_next and
        // no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE:    if (accept) state_next = ST_REQ;
            ST_REQ:     if (ack_s)  state_next = ST_RELEASE;
            ST_RELEASE: if (!ack_s) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge source_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            xfer_req  <= 1'b0;
            xfer_done <= 1'b0;
            // NOTE: the data register is reset as well, so the destination
            // sees a defined INIT_VALUE before the first transfer.
            xfer_data <= INIT_VALUE;
        end else begin
            state     <= state_next;
            // req is a direct register of "next state is REQ", so it rises on
            // accept and falls on the edge that moves to RELEASE.
            xfer_req  <= (state_next == ST_REQ);
            xfer_done <= (state == ST_RELEASE) && (state_next == ST_IDLE);
            if (accept) begin
                xfer_data <= in_data;
            end
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_busy;
    logic             wd_restart;
    logic             wd_hit;
    logic             timeout_q;

    assign wd_busy    = (state != ST_IDLE);
    assign wd_restart = !wd_busy || (state_next != state);
    // Flag sets on the edge where the count reaches TIMEOUT_CYCLES.
    assign wd_hit     = !wd_restart && (wd_cnt == WD_LAST);

    always_ff @(posedge source_clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wd_restart) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (err_clr) begin
                timeout_q <= 1'b0;
            end else if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_wd_cfg;

    assign unused_wd_cfg = err_clr ^ (TIMEOUT_CYCLES != 0);
    assign timeout_err   = 1'b0;
`endif

endmodule : cdc_hs_tx
